sync_frame_picker: RTL
======================

Name: sync_frame_picker

Overview:
Parametrised successor to the fixed 16-pixel sync picker. Hunts a configurable sync preamble (SYNC_LEN × SYNC_WORD, then MARK_WORD), reads a control word that carries the pixel count, then forwards exactly that many pixels downstream. Adds valid/ready flow control, continuous (re-arm) mode, a header timeout and error/status reporting. Sits between the raw sensor word stream and the pixel FIFO/packer.

Parameters:
DW, 16, data word width
SYNC_WORD, 16'hFFFF, preamble word, DW bits
SYNC_LEN, 2, number of consecutive SYNC_WORDs required, 1..8
MARK_WORD, 16'hAAAA, marker word that follows the preamble
MAX_PIX, 1024, largest legal pixel count
CNT_W, $clog2(MAX_PIX+1), pixel-count width, ≤ DW
TIMEOUT, 50000000, cycle limit from GO (or re-arm) to CNTL accepted

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
GO  in  1  start hunt, sampled in IDLE only
CONT  in  1  continuous mode: after a frame, re-arm hunt instead of returning to IDLE
DIN_VALID  in  1  input word valid
DIN  in  DW  input word
DIN_READY  out  1  block accepts DIN this cycle
OUT_READY  in  1  downstream can take a pixel
PUSH  out  1  pixel beat valid, equals DIN_VALID && DIN_READY in ePIX
PIXEL_DATA  out  DW  DIN during PUSH, else 0
BUSY  out  1  state != IDLE
DONE  out  1  1-cycle pulse, cycle after last pixel beat
ERR_LEN  out  1  1-cycle pulse, illegal length in control word
ERR_TIMEOUT  out  1  1-cycle pulse, header timeout
FRAME_CNT  out  16  frames completed, wraps FFFF->0

Behaviour:
- Reset (async, nRST low): state IDLE, remaining count 0, timeout counter 0, FRAME_CNT 0; DONE/ERR_* 0; DIN_READY, PUSH 0; PIXEL_DATA 0. Reset mid-frame aborts it with no DONE or error pulse.
- Accepted word = DIN_VALID && DIN_READY; every transition below occurs only on an accepted word unless noted.
- DIN_READY: 0 in IDLE; 1 in eSYNC/eMARK/eCNTL; OUT_READY in ePIX (combinational pass-through).
- States: eIDLE, eSYNC, eMARK, eCNTL, ePIX; sync_idx counts 0..SYNC_LEN-1.
- eIDLE: GO=1 -> eSYNC, sync_idx=0, timeout counter cleared.
- eSYNC: word==SYNC_WORD -> sync_idx+1, or eMARK once SYNC_LEN words matched; any other word -> sync_idx=0, stay eSYNC.
- eMARK: MARK_WORD -> eCNTL; SYNC_WORD -> stay eMARK (extra preamble tolerated); other -> eSYNC, sync_idx=0.
- eCNTL: len = DIN[CNT_W-1:0]; upper bits ignored. len==0 or len>MAX_PIX -> ERR_LEN pulse next cycle, go to re-arm target. Else remaining=len -> ePIX.
- ePIX: each accepted beat: PUSH=1, PIXEL_DATA=DIN same cycle (zero latency), remaining-1. Beat with remaining==1 -> DONE pulse next cycle, FRAME_CNT+1, go to re-arm target. No accepted beat = no decrement; OUT_READY low stalls indefinitely.
- Re-arm target: CONT=1 -> eSYNC (sync_idx=0, timeout cleared); CONT=0 -> eIDLE. CONT sampled on the transition cycle.
- Timeout: counter increments every cycle in eSYNC/eMARK/eCNTL, held at 0 elsewhere. Reaching TIMEOUT-1 -> ERR_TIMEOUT pulse next cycle, eIDLE regardless of CONT. Timeout takes priority over a same-cycle accepted word. Not active in ePIX.
- GO outside eIDLE ignored.
- Only one of DONE, ERR_LEN, ERR_TIMEOUT can pulse in any cycle.
- Arithmetic: remaining CNT_W bits unsigned, never decremented below 1 in ePIX; timeout counter $clog2(TIMEOUT) bits.

Decomposition:
- Package sync_pick_pkg: state enum typedef (eIDLE..ePIX), default SYNC_WORD/MARK_WORD constants.
- One sub-module, pick_timeout: cycle counter with clear/enable inputs, expire output, parameter TIMEOUT. Everything else lives in sync_frame_picker.

Test Plan:
- Basic: GO, DIN valid every cycle FFFF,FFFF,AAAA,0004,P0..P3 -> PUSH exactly 4 cycles with P0..P3, DONE 1 cycle after P3, FRAME_CNT=1, BUSY drops.
- Hunt robustness: FFFF,1234,FFFF,FFFF,FFFF,AAAA,0002,x,y -> mismatch restarts hunt, extra FFFF tolerated in eMARK, 2 pixels x,y pushed.
- Backpressure: len=3, OUT_READY toggled 1,0,0,1,1 and DIN_VALID gaps -> DIN_READY follows OUT_READY, PUSH only on handshake cycles, 3 beats total, data order preserved.
- Length errors: control 0000 -> ERR_LEN pulse, no PUSH. Control 0401 (MAX_PIX=1024) -> ERR_LEN. Both return to IDLE with CONT=0.
- Continuous + timeout (TIMEOUT=20): CONT=1, two back-to-back frames -> FRAME_CNT=2 without second GO. Then idle stream of 0000 -> ERR_TIMEOUT after 20 cycles, state IDLE.
- Reset mid-frame: nRST low during ePIX with remaining=5 -> PUSH/DONE 0 immediately, FRAME_CNT 0. After release, GO plus full header works normally.

Source files
------------

// File: rtl/sync_pick_pkg.sv
// Shared types and defaults for the sync frame picker.
//   state_e        : picker FSM state encoding
//   SYNC_WORD_DEF  : default preamble word
//   MARK_WORD_DEF  : default marker word that follows the preamble
package sync_pick_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eSYNC,
    eMARK,
    eCNTL,
    ePIX
  } state_e;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hFFFF;
  localparam logic [15:0] MARK_WORD_DEF = 16'hAAAA;

endpackage

// File: rtl/sync_frame_picker_if.sv
// Word stream in / pixel stream out bundle of the sync frame picker.
//   din_valid, din  : raw sensor words from upstream
//   din_ready       : picker accepts din this cycle
//   out_ready       : downstream can take a pixel
//   push, pixel_data: pixel beat to downstream (pixel_data is 0 when push is low)
// master = stream source/sink side, slave = the picker.
interface sync_frame_picker_if #(
  parameter int unsigned DW = 16
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          out_ready;
  logic          push;
  logic [DW-1:0] pixel_data;

  modport master (
    output din_valid, din, out_ready,
    input  din_ready, push, pixel_data
  );

  modport slave (
    input  din_valid, din, out_ready,
    output din_ready, push, pixel_data
  );
endinterface

// File: rtl/pick_timeout.sv
// Header timeout counter.
//   CLK, nRST : clock, asynchronous active-low reset
//   clr       : restart the count from 0
//   en        : count this cycle; when low the counter is held at 0
//   expire    : counter has reached TIMEOUT-1 while enabled
module pick_timeout #(
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = en && (cnt_q == TW'(TIMEOUT - 1));
    cnt_d  = (clr || !en || expire) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sync_frame_picker.sv
// Hunts SYNC_LEN x SYNC_WORD followed by MARK_WORD, reads a control word carrying the
// pixel count, then forwards exactly that many pixels with valid/ready flow control.
//   CLK, nRST   : clock, asynchronous active-low reset
//   go          : start a hunt (sampled in eIDLE only)
//   cont        : re-arm the hunt after a frame or length error instead of idling
//   bus         : word input / pixel output stream (slave side)
//   busy        : state is not eIDLE
//   done        : 1-cycle pulse after the last pixel beat
//   err_len     : 1-cycle pulse, control word length 0 or above MAX_PIX
//   err_timeout : 1-cycle pulse, header not completed within TIMEOUT cycles
//   frame_cnt   : completed frames, wrapping
module sync_frame_picker
  import sync_pick_pkg::*;
#(
  parameter int unsigned   DW        = 16,
  parameter logic [DW-1:0] SYNC_WORD = DW'(SYNC_WORD_DEF),
  parameter int unsigned   SYNC_LEN  = 2,
  parameter logic [DW-1:0] MARK_WORD = DW'(MARK_WORD_DEF),
  parameter int unsigned   MAX_PIX   = 1024,
  parameter int unsigned   CNT_W     = $clog2(MAX_PIX + 1),
  parameter int unsigned   TIMEOUT   = 50000000
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 go,
  input  logic                 cont,
  sync_frame_picker_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic [15:0]          frame_cnt
);

  state_e             state;
  logic [2:0]         sync_idx;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   len;
  logic               ready;
  logic               acc;
  logic               len_bad;
  logic               last_beat;
  logic               rearm;
  logic               tmo_en;
  logic               tmo_clr;
  logic               expire;

  always_comb begin
    len       = bus.din[CNT_W-1:0];
    len_bad   = (len == '0) || (32'(len) > MAX_PIX);
    unique case (state)
      eSYNC, eMARK, eCNTL: ready = 1'b1;
      ePIX:                ready = bus.out_ready;
      default:             ready = 1'b0;
    endcase
    acc            = bus.din_valid && ready;
    bus.din_ready  = ready;
    bus.push       = (state == ePIX) && acc;
    bus.pixel_data = bus.push ? bus.din : '0;
    last_beat      = (state == ePIX) && acc && (rem == CNT_W'(1));
    rearm          = ((state == eCNTL) && acc && len_bad) || last_beat;
    tmo_en         = (state == eSYNC) || (state == eMARK) || (state == eCNTL);
    tmo_clr        = ((state == eIDLE) && go) || (rearm && cont);
    busy           = (state != eIDLE);
  end

  pick_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (expire)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= eIDLE;
      sync_idx    <= '0;
      rem         <= '0;
      frame_cnt   <= '0;
      done        <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      // Timeout beats any word accepted in the same cycle, so it is tested first.
      if (tmo_en && expire) begin
        state       <= eIDLE;
        sync_idx    <= '0;
        err_timeout <= 1'b1;
      end else begin
        case (state)
          eIDLE: begin
            if (go) begin
              state    <= eSYNC;
              sync_idx <= '0;
            end
          end
          eSYNC: begin
            if (acc) begin
              if (bus.din == SYNC_WORD) begin
                if (sync_idx == 3'(SYNC_LEN - 1)) begin
                  state    <= eMARK;
                  sync_idx <= '0;
                end else begin
                  sync_idx <= sync_idx + 3'd1;
                end
              end else begin
                sync_idx <= '0;
              end
            end
          end
          eMARK: begin
            if (acc) begin
              if (bus.din == MARK_WORD) begin
                state <= eCNTL;
              end else if (bus.din != SYNC_WORD) begin
                state    <= eSYNC;
                sync_idx <= '0;
              end
            end
          end
          eCNTL: begin
            if (acc) begin
              if (len_bad) begin
                err_len  <= 1'b1;
                state    <= cont ? eSYNC : eIDLE;
                sync_idx <= '0;
              end else begin
                rem   <= len;
                state <= ePIX;
              end
            end
          end
          ePIX: begin
            if (acc) begin
              if (last_beat) begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
                state     <= cont ? eSYNC : eIDLE;
                sync_idx  <= '0;
              end else begin
                rem <= rem - CNT_W'(1);
              end
            end
          end
          default: state <= eIDLE;
        endcase
      end
    end
  end

endmodule
